// File: rtl/menu_screen_painter.sv
// Raster sweep that feeds the menu text setter and paints its answer
// pixel by pixel into the VGA adapter, one pixel per cycle.
//
// Ports:
//   clk, resetn          : clock, async active-low reset
//   start                : level request to begin a pass (sampled in IDLE)
//   repeat_en            : restart a pass straight after DONE
//   inmenu               : menu mode flag, gates text colour
//   menu_text            : registered text-setter answer for last pointer
//   x_pointer, y_pointer : coordinate presented to the text setter
//   vga_x, vga_y         : VGA write coordinate (pointer delayed a cycle)
//   vga_colour, vga_plot : VGA write colour and enable
//   busy, done           : pass in progress / pass complete pulse
module menu_screen_painter #(
  parameter int         WIDTH     = 160,
  parameter int         HEIGHT    = 120,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       repeat_en,
  input  logic       inmenu,
  input  logic       menu_text,
  output logic [7:0] x_pointer,
  output logic [6:0] y_pointer,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       x_last;
  logic       y_last;
  logic       scan_valid;
  logic       inmenu_d;

  assign x_last     = (x_pointer == X_LAST);
  assign y_last     = (y_pointer == Y_LAST);
  assign scan_valid = (state == SCAN);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (x_last && y_last) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = repeat_en ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
    end
  end

  // Pointer only advances while scanning; the final pixel wraps back
  // to the origin so it already sits at (0,0) for FLUSH/DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_pointer <= '0;
      y_pointer <= '0;
    end else if (scan_valid) begin
      if (x_last) begin
        x_pointer <= '0;
        y_pointer <= y_last ? '0 : y_pointer + 7'd1;
      end else begin
        x_pointer <= x_pointer + 8'd1;
      end
    end else begin
      x_pointer <= '0;
      y_pointer <= '0;
    end
  end

  // Delay the pointer by one cycle to line up with the registered
  // menu_text answer coming back from the text setter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x    <= '0;
      vga_y    <= '0;
      vga_plot <= 1'b0;
      inmenu_d <= 1'b0;
    end else begin
      vga_x    <= x_pointer;
      vga_y    <= y_pointer;
      vga_plot <= scan_valid;
      inmenu_d <= inmenu;
    end
  end

  // menu_text is stale outside menu mode, so it must be gated.
  assign vga_colour = (inmenu_d && menu_text) ? FG_COLOUR : BG_COLOUR;

endmodule

// File: tb/tb_menu_screen_painter.sv
// Bench for menu_screen_painter: behavioural frame model checked every
// cycle plus literal timing and pixel expectations.
module tb_menu_screen_painter;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int NP = W * H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic       repeat_en;
  logic       inmenu;
  logic       menu_text = 1'b0;
  logic [7:0] x_pointer;
  logic [6:0] y_pointer;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  logic force_text = 1'b0;

  int checks = 0;
  int errors = 0;

  menu_screen_painter dut (
    .clk(clk), .resetn(resetn), .start(start),
    .repeat_en(repeat_en), .inmenu(inmenu), .menu_text(menu_text),
    .x_pointer(x_pointer), .y_pointer(y_pointer),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic txt(int x, int y);
    return x >= 10 && x < 150 && y >= 10 && y < 60 &&
           (((x >> 1) & 1) == ((y >> 1) & 1));
  endfunction

  // Text setter stand-in: registered answer, stale while not in menu.
  always @(posedge clk)
    if (force_text) menu_text <= 1'b1;
    else if (inmenu) menu_text <= txt(int'(x_pointer), int'(y_pointer));

  // Frame model: t = edges since the start-sampling edge of a pass.
  bit m_idle = 1'b1;
  int t = 0;
  bit m_inm;
  int cyc = 0;
  bit prev_plot = 1'b0;
  int starts[$];
  int plot_starts[$];
  int done_cycs[$];
  int last_plot;
  int plot_cnt;
  int fg_cnt;
  int done_cnt;
  logic [2:0] pix_a, pix_b, pix_c, pix_d;

  task automatic clear_stats();
    starts.delete();
    plot_starts.delete();
    done_cycs.delete();
    last_plot = -1;
    plot_cnt = 0;
    fg_cnt = 0;
    done_cnt = 0;
    pix_a = 3'b010;
    pix_b = 3'b010;
    pix_c = 3'b010;
    pix_d = 3'b010;
  endtask

  task automatic compare();
    int px, py;
    bit exp_plot;
    logic [2:0] exp_col;
    chk("x_range", 32'(x_pointer < W), 1);
    chk("y_range", 32'(y_pointer < H), 1);
    if (m_idle) begin
      chk("idle_ptr", {x_pointer, y_pointer}, 0);
      chk("idle_plot", vga_plot, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end else begin
      chk("busy", busy, 1);
      chk("done", done, 32'(t == NP + 1));
      if (t < NP) begin
        chk("ptr_x", x_pointer, t % W);
        chk("ptr_y", y_pointer, t / W);
      end else begin
        chk("ptr_hold", {x_pointer, y_pointer}, 0);
      end
      exp_plot = (t >= 1 && t <= NP);
      chk("plot", vga_plot, 32'(exp_plot));
      if (exp_plot) begin
        px = (t - 1) % W;
        py = (t - 1) / W;
        exp_col = (m_inm && txt(px, py)) ? 3'b111 : 3'b000;
        chk("vga_x", vga_x, px);
        chk("vga_y", vga_y, py);
        chk("colour", vga_colour, exp_col);
      end
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_idle = 1'b1;
      t = 0;
      cyc++;
    end else begin
      cyc++;
      m_inm = inmenu;
      if (m_idle) begin
        if (start) begin
          m_idle = 1'b0;
          t = 0;
          starts.push_back(cyc);
        end
      end else if (t == NP + 1) begin
        if (repeat_en) begin
          t = 0;
          starts.push_back(cyc);
        end else begin
          m_idle = 1'b1;
        end
      end else begin
        t++;
      end
      #1;
      if (resetn) begin
        compare();
        if (vga_plot) begin
          if (!prev_plot) plot_starts.push_back(cyc);
          last_plot = cyc;
          plot_cnt++;
          if (vga_colour != 3'b000) fg_cnt++;
          if (vga_x == 12 && vga_y == 12) pix_a = vga_colour;
          if (vga_x == 133 && vga_y == 52) pix_b = vga_colour;
          if (vga_x == 0 && vga_y == 0) pix_c = vga_colour;
          if (vga_x == 40 && vga_y == 60) pix_d = vga_colour;
        end
        if (done) begin
          done_cnt++;
          done_cycs.push_back(cyc);
        end
        prev_plot = vga_plot;
      end else begin
        prev_plot = 1'b0;
      end
    end
  end

  task automatic wait_done(int n, string n_name);
    for (int i = 0; i < 2 * NP + 100 && done_cnt < n; i++)
      @(negedge clk);
    chk(n_name, 32'(done_cnt >= n), 1);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    repeat_en = 1'b0;
    inmenu = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk);
    chk("rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
    chk("rst_ptr", {x_pointer, y_pointer}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Reset in the middle of a pass at pixel (37,5).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (x_pointer == 37 && y_pointer == 5) break;
      @(negedge clk);
    end
    chk("reach_37_5", {x_pointer, y_pointer}, {8'd37, 7'd5});
    chk("pre_rst_plot", vga_plot, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_vga", {vga_x, vga_y, vga_colour, vga_plot}, 0);
    chk("mid_rst_ptr", {x_pointer, y_pointer}, 0);
    chk("mid_rst_busy_done", {busy, done}, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_plot", vga_plot, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_plot", vga_plot, 0);

    // Full pass in menu mode, with a stray start at pixel 500.
    clear_stats();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NP && plot_cnt < 500; i++) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(1, "pass1_timeout");
    repeat (4) @(negedge clk);
    chk("p1_plots", plot_cnt, NP);
    chk("p1_dones", done_cnt, 1);
    chk("p1_starts", starts.size(), 1);
    if (starts.size() > 0 && plot_starts.size() > 0) begin
      chk("p1_first", plot_starts[0] - starts[0], 1);
      chk("p1_last", last_plot - starts[0], NP);
    end
    if (starts.size() > 0 && done_cycs.size() > 0)
      chk("p1_done_at", done_cycs[0] - starts[0], NP + 1);
    chk("pix_12_12", pix_a, 3'b111);
    chk("pix_133_52", pix_b, 3'b111);
    chk("pix_0_0", pix_c, 3'b000);
    chk("pix_40_60", pix_d, 3'b000);
    chk("p1_idle", busy, 0);

    // Two back-to-back passes, menu off, text setter stuck at 1.
    clear_stats();
    inmenu = 1'b0;
    force_text = 1'b1;
    repeat_en = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, "pass2_timeout");
    @(negedge clk);
    repeat_en = 1'b0;
    chk("boundary_busy", busy, 1);
    wait_done(2, "pass3_timeout");
    repeat (4) @(negedge clk);
    chk("rep_plots", plot_cnt, 2 * NP);
    chk("rep_fg", fg_cnt, 0);
    chk("rep_dones", done_cnt, 2);
    chk("rep_runs", plot_starts.size(), 2);
    if (plot_starts.size() == 2)
      chk("rep_period", plot_starts[1] - plot_starts[0], NP + 2);
    chk("rep_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
